// File: rtl/pipelined_ripple_adder_if.sv
// Operand/result bundle for pipelined_ripple_adder.
// The master side issues operations; the slave side (the adder) returns results.
interface pipelined_ripple_adder_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, sub, a, b, cin,
        input  out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, sub, a, b, cin,
        output out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/pipelined_ripple_adder.sv
// Path-balanced ripple-carry adder/subtractor: one STAGE_BITS-wide carry slice per
// pipeline stage, with skew registers for unconsumed operand bits and deskew for sums.
module pipelined_ripple_adder #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned STAGE_BITS = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    pipelined_ripple_adder_if.slave  bus
);
    localparam int unsigned S = (WIDTH + STAGE_BITS - 1) / STAGE_BITS;

    // r_a/r_b/r_c[k]: operands and carry entering slice k; r_sum[k]: sum after slice k.
    logic [S:0]       r_v;
    logic [WIDTH-1:0] r_a   [S];
    logic [WIDTH-1:0] r_b   [S];
    logic [S-1:0]     r_c;
    logic [WIDTH-1:0] r_sum [S];
    logic             r_cout;
    logic             r_ovf;

    logic [WIDTH-1:0] w_sum_nxt [S];
    logic [S-1:0]     w_c_nxt;
    logic             w_cmsb;
    logic             w_c;
    logic [WIDTH-1:0] w_s;

    always_comb begin
        w_sum_nxt = '{default: '0};
        w_c_nxt   = '0;
        w_cmsb    = 1'b0;
        w_c       = 1'b0;
        w_s       = '0;
        for (int unsigned k = 0; k < S; k++) begin
            w_c = r_c[k];
            w_s = (k == 0) ? '0 : r_sum[(k == 0) ? 0 : k - 1];
            for (int unsigned n = k * STAGE_BITS; n < WIDTH && n < (k + 1) * STAGE_BITS; n++) begin
                if (n == WIDTH - 1) begin
                    w_cmsb = w_c;
                end
                w_s[n] = r_a[k][n] ^ r_b[k][n] ^ w_c;
                w_c    = (r_a[k][n] & r_b[k][n]) | (w_c & (r_a[k][n] ^ r_b[k][n]));
            end
            w_sum_nxt[k] = w_s;
            w_c_nxt[k]   = w_c;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v    <= '0;
            r_c    <= '0;
            r_cout <= 1'b0;
            r_ovf  <= 1'b0;
            for (int unsigned k = 0; k < S; k++) begin
                r_a[k]   <= '0;
                r_b[k]   <= '0;
                r_sum[k] <= '0;
            end
        end else begin
            r_v <= {r_v[S-1:0], bus.in_valid};
            if (bus.in_valid) begin
                r_a[0] <= bus.a;
                r_b[0] <= bus.b ^ {WIDTH{bus.sub}};
                r_c[0] <= bus.sub | bus.cin;
            end
            for (int unsigned k = 1; k < S; k++) begin
                if (r_v[k-1]) begin
                    r_a[k] <= r_a[k-1];
                    r_b[k] <= r_b[k-1];
                    r_c[k] <= w_c_nxt[k-1];
                end
            end
            for (int unsigned k = 0; k < S; k++) begin
                if (r_v[k]) begin
                    r_sum[k] <= w_sum_nxt[k];
                end
            end
            if (r_v[S-1]) begin
                r_cout <= w_c_nxt[S-1];
                r_ovf  <= w_cmsb ^ w_c_nxt[S-1];
            end
        end
    end

    assign bus.out_valid = r_v[S];
    assign bus.sum       = r_sum[S-1];
    assign bus.cout      = r_cout;
    assign bus.ovf       = r_ovf;
endmodule

// File: tb/tb_pipelined_ripple_adder.sv
// Bench for pipelined_ripple_adder: three geometries (8/2, 7/3, 1/1) checked against
// an integer-arithmetic reference model.
module tb_pipelined_ripple_adder;
    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    pipelined_ripple_adder_if #(.WIDTH(8)) b8 ();
    pipelined_ripple_adder_if #(.WIDTH(7)) b7 ();
    pipelined_ripple_adder_if #(.WIDTH(1)) b1 ();

    pipelined_ripple_adder #(.WIDTH(8), .STAGE_BITS(2)) u8 (.clk(clk), .rst(rst), .bus(b8));
    pipelined_ripple_adder #(.WIDTH(7), .STAGE_BITS(3)) u7 (.clk(clk), .rst(rst), .bus(b7));
    pipelined_ripple_adder #(.WIDTH(1), .STAGE_BITS(1)) u1 (.clk(clk), .rst(rst), .bus(b1));

    function automatic int lat(input int d);
        return (d == 0) ? 4 : (d == 1) ? 3 : 1;
    endfunction

    function automatic int wid(input int d);
        return (d == 0) ? 8 : (d == 1) ? 7 : 1;
    endfunction

    // Returns {ovf, cout, sum} from plain unsigned/signed integer arithmetic.
    function automatic logic [9:0] ref_op(input int w, input int a, input int b, input bit s, input bit c);
        int m, sa, sb, u, sr;
        bit co, ov;
        logic [7:0] sm;
        m  = 1 << w;
        a  = a % m;
        b  = b % m;
        sa = (a >= m / 2) ? a - m : a;
        sb = (b >= m / 2) ? b - m : b;
        if (!s) begin
            u  = a + b + int'(c);
            sr = sa + sb + int'(c);
            co = (u >= m);
        end else begin
            u  = a - b;
            sr = sa - sb;
            co = (a >= b);
        end
        sm = 8'(((u % m) + m) % m);
        ov = (sr < -(m / 2)) || (sr > m / 2 - 1);
        return {ov, co, sm};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int d, input bit v, input logic [7:0] a, input logic [7:0] b,
                         input bit s, input bit c);
        case (d)
            0: begin b8.in_valid = v; b8.sub = s; b8.a = a;      b8.b = b;      b8.cin = c; end
            1: begin b7.in_valid = v; b7.sub = s; b7.a = a[6:0]; b7.b = b[6:0]; b7.cin = c; end
            default: begin b1.in_valid = v; b1.sub = s; b1.a = a[0]; b1.b = b[0]; b1.cin = c; end
        endcase
    endtask

    task automatic get(input int d, output logic v, output logic [9:0] r);
        case (d)
            0: begin v = b8.out_valid; r = {b8.ovf, b8.cout, b8.sum}; end
            1: begin v = b7.out_valid; r = {b7.ovf, b7.cout, 1'b0, b7.sum}; end
            default: begin v = b1.out_valid; r = {b1.ovf, b1.cout, 7'b0, b1.sum}; end
        endcase
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation, then check it appears exactly lat(d) edges later for one cycle.
    task automatic op(input int d, input logic [7:0] a, input logic [7:0] b, input bit s,
                      input bit c, input logic [9:0] exp, input string tag);
        logic v;
        logic [9:0] r;
        drive(d, 1'b1, a, b, s, c);
        cycle();
        drive(d, 1'b0, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
        repeat (lat(d) - 1) cycle();
        get(d, v, r);
        chk({tag, "_early_v"}, 32'(v), 32'd0);
        cycle();
        get(d, v, r);
        chk({tag, "_v"}, 32'(v), 32'd1);
        chk({tag, "_res"}, 32'(r), 32'(exp));
        cycle();
        get(d, v, r);
        chk({tag, "_after_v"}, 32'(v), 32'd0);
        chk({tag, "_hold"}, 32'(r), 32'(exp));
    endtask

    initial begin
        logic v;
        logic [9:0] r, e, last;
        logic [7:0] ra, rb;
        bit rs, rc, rv, ev;
        logic [9:0] er;
        bit q_v[$];
        logic [9:0] q_r[$];
        int issued, iter, drain;

        rst = 1'b1;
        for (int d = 0; d < 3; d++) drive(d, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        #1;
        get(0, v, r); chk("rst8_v", 32'(v), 32'd0); chk("rst8_res", 32'(r), 32'd0);
        get(1, v, r); chk("rst7_v", 32'(v), 32'd0); chk("rst7_res", 32'(r), 32'd0);
        get(2, v, r); chk("rst1_v", 32'(v), 32'd0); chk("rst1_res", 32'(r), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        op(0, 8'hFF, 8'h01, 1'b0, 1'b0, {1'b0, 1'b1, 8'h00}, "add_wrap");
        op(0, 8'h7F, 8'h00, 1'b0, 1'b1, {1'b1, 1'b0, 8'h80}, "add_ovf_cin");
        op(0, 8'h05, 8'h07, 1'b1, 1'b0, {1'b0, 1'b0, 8'hFE}, "sub_neg");
        op(0, 8'h80, 8'h01, 1'b1, 1'b0, {1'b1, 1'b1, 8'h7F}, "sub_ovf");
        op(0, 8'h05, 8'h07, 1'b1, 1'b1, {1'b0, 1'b0, 8'hFE}, "sub_cin_ignored");

        op(1, 8'h7F, 8'h7F, 1'b0, 1'b1, {1'b0, 1'b1, 8'h7F}, "w7_full");
        for (int i = 0; i < 6; i++) begin
            ra = 8'($urandom) & 8'h7F; rb = 8'($urandom) & 8'h7F;
            rs = 1'($urandom); rc = 1'($urandom);
            op(1, ra, rb, rs, rc, ref_op(wid(1), ra, rb, rs, rc), $sformatf("w7_rand%0d", i));
        end

        for (int i = 0; i < 8; i++) begin
            ra = 8'(i & 1); rb = 8'((i >> 1) & 1); rc = 1'(i >> 2);
            e  = {ref_op(1, ra, rb, 1'b0, rc)};
            chk($sformatf("fa_model%0d", i), 32'(e[8:0]), 32'({ra[0] & rb[0] | rc & (ra[0] ^ rb[0]), 7'b0, ra[0] ^ rb[0] ^ rc}));
            op(2, ra, rb, 1'b0, rc, e, $sformatf("fa%0d", i));
        end

        // Reset mid-cycle with one result showing and another in flight.
        drive(0, 1'b1, 8'h12, 8'h34, 1'b0, 1'b0); cycle();
        drive(0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0); cycle();
        drive(0, 1'b1, 8'h55, 8'h11, 1'b0, 1'b1); cycle();
        drive(0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0); cycle();
        cycle();
        get(0, v, r);
        chk("pre_rst_v", 32'(v), 32'd1);
        chk("pre_rst_res", 32'(r), 32'h046);
        #2 rst = 1'b1;
        #1;
        get(0, v, r);
        chk("async_rst_v", 32'(v), 32'd0);
        chk("async_rst_res", 32'(r), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cycle();
            get(0, v, r);
            chk("post_rst_v", 32'(v), 32'd0);
            chk("post_rst_res", 32'(r), 32'd0);
        end

        // Streaming with random gaps; outputs must hold between valid results.
        last = '0; issued = 0; iter = 0; drain = 0;
        while (drain < 6 && iter < 400) begin
            iter++;
            rv = (issued < 32) && ($urandom_range(0, 2) != 0);
            ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom); rc = 1'($urandom);
            drive(0, rv, ra, rb, rs, rc);
            cycle();
            if (rv) issued++;
            if (issued == 32 && !rv) drain++;
            q_v.push_back(rv);
            q_r.push_back(ref_op(8, ra, rb, rs, rc));
            ev = 1'b0;
            if (q_v.size() == 5) begin
                ev = q_v.pop_front();
                er = q_r.pop_front();
                if (ev) last = er;
            end
            get(0, v, r);
            chk("stream_v", 32'(v), 32'(ev));
            chk("stream_res", 32'(r), 32'(last));
        end
        chk("stream_issued", 32'(issued), 32'd32);
        chk("stream_drained", 32'(drain), 32'd6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
